queue_alu_seq: RTL and testbench
================================

Name: queue_alu_seq

Overview:
- Sequential, parametrised ALU for the queue calculator. It sits between the opcode decoder and the operand queue.
- Accepts one operation per handshake and returns a registered result plus a queue command (push / pop / get-and-push / sleep).
- Generalises the combinational ALU in three ways: configurable data width, valid/ready handshakes on both sides, and a multi-cycle restoring divider for DIV/REM.
- Adds overflow and divide-by-zero reporting, with a sticky error flag.

Parameters:
- W, 8, data width; operands bus is 2*W, result is W.
- PUSH_CODE/POP_CODE/ADD_CODE/MULL_CODE/SUB_CODE/DIV_CODE/REM_CODE, 4'h0..4'h6, opcode encodings (unchanged from current ALU).
- Q_PUSH, 2'b00, Q_SLEEP, 2'b01, Q_POP, 2'b11, Q_GET_AND_PUSH, 2'b10, queue command encodings.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  opcode/operands/push_val valid.
- in_ready  out  1  block can accept an operation.
- opcode  in  4  operation select.
- operands  in  2*W  A=operands[2W-1:W], B=operands[W-1:0].
- push_val  in  W  value for PUSH.
- out_valid  out  1  result/queue_op/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  registered result.
- queue_op  out  2  registered queue command.
- ovf  out  1  arithmetic overflow/borrow for this result.
- has_calc_err  out  1  divide-by-zero for this result.
- err_sticky  out  1  set by any has_calc_err result; cleared only by reset.
- busy  out  1  high while the divider iterates.

Behaviour:
- Reset (rst=0, async): state=IDLE, out_valid=0, result=0, queue_op=Q_SLEEP, ovf=0, has_calc_err=0, err_sticky=0, busy=0, divider registers=0.
- Reset mid-division aborts the operation; no result is produced.
- in_ready = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back single-cycle ops at one per clock.
- Accept happens when in_valid && in_ready. Inputs are sampled only at accept and may change afterwards.
- Output held stable while out_valid && !out_ready. out_valid drops on out_ready unless a new result loads the same cycle.
- States:
  - IDLE: accept an operation.
  - DIV: iterate.
  - No separate DONE state; the output register holds the result.
- Single-cycle ops (result and out_valid appear the cycle after accept):
  - PUSH: result=push_val, queue_op=Q_PUSH, ovf=0.
  - POP: result=0, queue_op=Q_POP.
  - ADD: result=(A+B) mod 2^W, ovf=carry out.
  - MULL: result=low W bits of A*B, ovf = high W bits != 0.
  - SUB: result=(B-A) mod 2^W, ovf=borrow (A>B).
  - ADD/MULL/SUB: queue_op=Q_GET_AND_PUSH.
  - Undefined opcode: result=0, queue_op=Q_SLEEP, no flags.
- DIV/REM with A==0:
  - No iteration; 1-cycle latency.
  - result=0, queue_op=Q_SLEEP, has_calc_err=1, err_sticky set.
- DIV/REM with A!=0:
  - Enter DIV with busy=1. Restoring division, one quotient bit per cycle, W cycles.
  - out_valid rises W+1 cycles after accept.
  - DIV: result=B/A. REM: result=B%A (remainder by A only, never by the full operand bus).
  - queue_op=Q_GET_AND_PUSH, ovf=0.
  - Return to IDLE when the final result is loaded.
- has_calc_err and ovf are per-result and change only when a new result loads.
- All outputs are registered; there is no combinational input-to-output path except in_ready←out_ready.

Decomposition:
- Package queue_calc_pkg holds:
  - opcode localparams;
  - Q_* queue command localparams;
  - FSM state encoding (IDLE, DIV).
- One sub-module, queue_div_iter, parametrised by W:
  - inputs: start, dividend, divisor;
  - outputs: done, quotient, remainder;
  - fixed W-cycle latency.
- The ALU top holds the single-cycle datapath, handshake logic, and output register.

Test Plan (W=8):
- ADD A=200, B=100 → result=44, ovf=1, queue_op=2'b10, out_valid one cycle after accept.
- SUB A=5, B=3 → result=254, ovf=1; then MULL A=16, B=16 → result=0, ovf=1; back-to-back accepts with out_ready=1, one result per clock.
- DIV A=7, B=100 → busy for 8 cycles, result=14, out_valid 9 cycles after accept, in_ready=0 throughout. REM same operands → result=2.
- DIV A=0, B=50 → next cycle result=0, queue_op=Q_SLEEP, has_calc_err=1, err_sticky=1. Following ADD 1+1 → has_calc_err=0, err_sticky stays 1.
- Backpressure: PUSH 0x5A with out_ready=0 for 4 cycles → result holds 0x5A, in_ready=0; release → out_valid drops, next op accepted.
- Assert rst=0 at cycle 3 of a DIV → all outputs at reset values immediately. After release, no stale result appears and in_ready=1.

Source files
------------

// File: rtl/queue_alu_seq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : queue_calc_pkg
// Brief  : Opcode, queue-command and FSM state encodings for the queue ALU.
// Rev    : 1.0
// ============================================================================
package queue_calc_pkg;

    localparam logic [3:0] PUSH_CODE = 4'h0;
    localparam logic [3:0] POP_CODE  = 4'h1;
    localparam logic [3:0] ADD_CODE  = 4'h2;
    localparam logic [3:0] MULL_CODE = 4'h3;
    localparam logic [3:0] SUB_CODE  = 4'h4;
    localparam logic [3:0] DIV_CODE  = 4'h5;
    localparam logic [3:0] REM_CODE  = 4'h6;

    localparam logic [1:0] Q_PUSH         = 2'b00;
    localparam logic [1:0] Q_SLEEP        = 2'b01;
    localparam logic [1:0] Q_POP          = 2'b11;
    localparam logic [1:0] Q_GET_AND_PUSH = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        DIV  = 1'b1
    } alu_state_t;

endpackage : queue_calc_pkg
`default_nettype wire

// File: rtl/queue_alu_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : queue_alu_seq_if
// Brief  : Operation-in / result-out handshake bundle of the queue ALU.
// Rev    : 1.0
// ============================================================================
interface queue_alu_seq_if #(
    parameter int W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [2*W-1:0]   operands;
    logic [W-1:0]     push_val;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [1:0]       queue_op;
    logic             ovf;
    logic             has_calc_err;
    logic             err_sticky;
    logic             busy;

    modport master (
        output in_valid, opcode, operands, push_val, out_ready,
        input  in_ready, out_valid, result, queue_op, ovf, has_calc_err,
               err_sticky, busy
    );

    modport slave (
        input  in_valid, opcode, operands, push_val, out_ready,
        output in_ready, out_valid, result, queue_op, ovf, has_calc_err,
               err_sticky, busy
    );
endinterface : queue_alu_seq_if
`default_nettype wire

// File: rtl/queue_alu_seq_div_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : queue_div_iter
// Brief  : Restoring divider, one quotient bit per cycle, fixed W-cycle latency.
// Rev    : 1.0
// ============================================================================
module queue_div_iter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);
    localparam int           CW         = $clog2(W + 1);
    localparam logic [CW-1:0] C_CNT_LOAD = CW'(W);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_quo;
    logic [W-1:0]  r_dvs;

    logic [W:0]    w_partial;
    logic [W:0]    w_diff;
    logic          w_fits;
    logic [W-1:0]  w_rem_nxt;
    logic [W-1:0]  w_quo_nxt;

    // The dividend shifts out of r_quo while quotient bits shift in behind it.
    always_comb begin
        w_partial = {r_rem, r_quo[W-1]};
        w_diff    = w_partial - {1'b0, r_dvs};
        w_fits    = (w_partial >= {1'b0, r_dvs});
        w_rem_nxt = w_fits ? w_diff[W-1:0] : w_partial[W-1:0];
        w_quo_nxt = {r_quo[W-2:0], w_fits};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
        end else if (start) begin
            r_cnt <= C_CNT_LOAD;
            r_rem <= '0;
            r_quo <= dividend;
            r_dvs <= divisor;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - C_CNT_ONE;
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
        end
    end

    // Final step is presented combinationally so the caller can register it directly.
    assign done      = (r_cnt == C_CNT_ONE);
    assign quotient  = w_quo_nxt;
    assign remainder = w_rem_nxt;

endmodule : queue_div_iter
`default_nettype wire

// File: rtl/queue_alu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : queue_alu_seq
// Brief  : Sequential queue-calculator ALU with handshakes and iterative DIV/REM.
// Rev    : 1.0
// ============================================================================
module queue_alu_seq
    import queue_calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic               clk,
    input  logic               rst,
    queue_alu_seq_if.slave     bus
);
    alu_state_t     r_state;
    alu_state_t     w_state_nxt;
    logic           r_is_rem;

    logic           r_out_valid;
    logic [W-1:0]   r_result;
    logic [1:0]     r_queue_op;
    logic           r_ovf;
    logic           r_err;
    logic           r_sticky;

    logic [W-1:0]   w_a;
    logic [W-1:0]   w_b;
    logic [W:0]     w_sum;
    logic [W:0]     w_diff;
    logic [2*W-1:0] w_prod;
    logic           w_in_ready;
    logic           w_accept;
    logic           w_load;
    logic           w_start;
    logic [W-1:0]   w_res;
    logic [1:0]     w_qop;
    logic           w_ovf;
    logic           w_err;

    logic           w_div_done;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;

    assign w_a    = bus.operands[2*W-1:W];
    assign w_b    = bus.operands[W-1:0];
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_b} - {1'b0, w_a};
    assign w_prod = {{W{1'b0}}, w_a} * {{W{1'b0}}, w_b};

    assign w_in_ready = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_start     = 1'b0;
        w_res       = '0;
        w_qop       = Q_SLEEP;
        w_ovf       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    case (bus.opcode)
                        PUSH_CODE: begin
                            w_res = bus.push_val;
                            w_qop = Q_PUSH;
                        end
                        POP_CODE: w_qop = Q_POP;
                        ADD_CODE: begin
                            w_res = w_sum[W-1:0];
                            w_ovf = w_sum[W];
                            w_qop = Q_GET_AND_PUSH;
                        end
                        MULL_CODE: begin
                            w_res = w_prod[W-1:0];
                            w_ovf = |w_prod[2*W-1:W];
                            w_qop = Q_GET_AND_PUSH;
                        end
                        SUB_CODE: begin
                            w_res = w_diff[W-1:0];
                            w_ovf = w_diff[W];
                            w_qop = Q_GET_AND_PUSH;
                        end
                        DIV_CODE, REM_CODE: begin
                            if (w_a == '0) begin
                                w_err = 1'b1;
                            end else begin
                                w_load      = 1'b0;
                                w_start     = 1'b1;
                                w_state_nxt = DIV;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            DIV: begin
                if (w_div_done) begin
                    w_load      = 1'b1;
                    w_res       = r_is_rem ? w_rem : w_quo;
                    w_qop       = Q_GET_AND_PUSH;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_is_rem <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_is_rem <= (bus.opcode == REM_CODE);
            end
        end
    end

    // A DIV is only accepted once the previous result has gone, so a load never overwrites.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_queue_op  <= Q_SLEEP;
            r_ovf       <= 1'b0;
            r_err       <= 1'b0;
            r_sticky    <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_queue_op  <= w_qop;
            r_ovf       <= w_ovf;
            r_err       <= w_err;
            r_sticky    <= r_sticky | w_err;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    queue_div_iter #(
        .W (W)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (w_start),
        .dividend  (w_b),
        .divisor   (w_a),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem)
    );

    assign bus.in_ready     = w_in_ready;
    assign bus.out_valid    = r_out_valid;
    assign bus.result       = r_result;
    assign bus.queue_op     = r_queue_op;
    assign bus.ovf          = r_ovf;
    assign bus.has_calc_err = r_err;
    assign bus.err_sticky   = r_sticky;
    assign bus.busy         = (r_state == DIV);

endmodule : queue_alu_seq
`default_nettype wire

// File: tb/tb_queue_alu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_queue_alu_seq
// Brief  : Scoreboard bench for queue_alu_seq with a plain-arithmetic reference model.
// Rev    : 1.0
// ============================================================================
module tb_queue_alu_seq;
    import queue_calc_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] result;
        logic [1:0]   qop;
        logic         ovf;
        logic         err;
        logic         sticky;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    queue_alu_seq_if #(.W(W)) bus ();

    queue_alu_seq #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    bit   sticky_m = 1'b0;
    bit   rand_ready = 1'b0;
    logic forced_ready = 1'b1;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
    end

    function automatic exp_t model(logic [3:0] op, logic [W-1:0] a, logic [W-1:0] b,
                                   logic [W-1:0] pv);
        exp_t   e;
        longint m  = longint'(1) << W;
        longint ai = longint'(a);
        longint bi = longint'(b);
        longint t;
        e.result = '0; e.qop = Q_SLEEP; e.ovf = 1'b0; e.err = 1'b0;
        case (op)
            PUSH_CODE: begin e.result = pv; e.qop = Q_PUSH; end
            POP_CODE:  e.qop = Q_POP;
            ADD_CODE:  begin
                t = ai + bi;
                e.result = W'(t % m); e.ovf = (t >= m); e.qop = Q_GET_AND_PUSH;
            end
            MULL_CODE: begin
                t = ai * bi;
                e.result = W'(t % m); e.ovf = (t >= m); e.qop = Q_GET_AND_PUSH;
            end
            SUB_CODE:  begin
                e.result = W'((bi - ai + m) % m); e.ovf = (ai > bi); e.qop = Q_GET_AND_PUSH;
            end
            DIV_CODE, REM_CODE: begin
                if (ai == 0) begin
                    e.err = 1'b1;
                    sticky_m = 1'b1;
                end else begin
                    e.result = (op == DIV_CODE) ? W'(bi / ai) : W'(bi % ai);
                    e.qop = Q_GET_AND_PUSH;
                end
            end
            default: ;
        endcase
        e.sticky = sticky_m;
        return e;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Monitor: a handshake completes at the posedge following a negedge with valid&&ready.
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.out_valid && bus.out_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_result: got result=%0d qop=%0d with no expected entry",
                         bus.result, bus.queue_op);
            end else begin
                e = sb.pop_front();
                if (bus.result !== e.result || bus.queue_op !== e.qop || bus.ovf !== e.ovf ||
                    bus.has_calc_err !== e.err || bus.err_sticky !== e.sticky) begin
                    fails++;
                    $display("FAIL scoreboard: got res=%0d qop=%0d ovf=%0d err=%0d sticky=%0d, expected res=%0d qop=%0d ovf=%0d err=%0d sticky=%0d",
                             bus.result, bus.queue_op, bus.ovf, bus.has_calc_err, bus.err_sticky,
                             e.result, e.qop, e.ovf, e.err, e.sticky);
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] pv);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.operands = {a, b};
        bus.push_val = pv;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready=%0d after %0d cycles, expected 1", bus.in_ready, n);
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
            return;
        end
        sb.push_back(model(op, a, b, pv));
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.opcode   = 4'($urandom);
        bus.operands = 16'($urandom);
        bus.push_val = 8'($urandom);
    endtask

    // Counts cycles from accept to out_valid, plus busy cycles; realigns to posedge+1.
    task automatic check_lat(input string name, input int exp_lat, input int exp_busy);
        int lat = 0;
        int busy_cnt = 0;
        int ir_bad = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
            if (bus.busy) begin
                busy_cnt++;
                if (bus.in_ready) ir_bad++;
            end
            if (bus.out_valid) break;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_busy_cycles"}, busy_cnt, exp_busy);
        if (exp_busy > 0) chk({name, "_in_ready_while_busy"}, ir_bad, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        logic [3:0] op;
        logic [W-1:0] a, b;
        int first_acc;
        int n;

        bus.in_valid = 1'b0;
        bus.opcode   = '0;
        bus.operands = '0;
        bus.push_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_result", bus.result, 0);
        chk("reset_queue_op", bus.queue_op, Q_SLEEP);
        chk("reset_flags", {bus.ovf, bus.has_calc_err, bus.err_sticky, bus.busy}, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        issue(ADD_CODE, 8'd200, 8'd100, 8'd0);
        check_lat("add", 1, 0);

        issue(SUB_CODE, 8'd5, 8'd3, 8'd0);
        first_acc = acc_cyc;
        issue(MULL_CODE, 8'd16, 8'd16, 8'd0);
        chk("back_to_back_accept_gap", acc_cyc - first_acc, 1);
        check_lat("mull", 1, 0);

        issue(DIV_CODE, 8'd7, 8'd100, 8'd0);
        check_lat("div", 9, 8);
        issue(REM_CODE, 8'd7, 8'd100, 8'd0);
        check_lat("rem", 9, 8);

        issue(DIV_CODE, 8'd0, 8'd50, 8'd0);
        check_lat("div_by_zero", 1, 0);
        issue(ADD_CODE, 8'd1, 8'd1, 8'd0);
        check_lat("add_after_err", 1, 0);

        forced_ready = 1'b0;
        @(posedge clk); #1;
        issue(PUSH_CODE, 8'd0, 8'd0, 8'h5A);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_result_hold", bus.result, 8'h5A);
            chk("bp_out_valid_hold", bus.out_valid, 1);
            chk("bp_in_ready_low", bus.in_ready, 0);
        end
        forced_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_out_valid_drop", bus.out_valid, 0);
        @(posedge clk); #1;
        issue(POP_CODE, 8'd3, 8'd4, 8'd0);
        check_lat("pop_after_bp", 1, 0);

        issue(DIV_CODE, 8'd7, 8'd100, 8'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_out_valid", bus.out_valid, 0);
        chk("midreset_result", bus.result, 0);
        chk("midreset_queue_op", bus.queue_op, Q_SLEEP);
        chk("midreset_flags", {bus.ovf, bus.has_calc_err, bus.err_sticky, bus.busy}, 0);
        sb.delete();
        sticky_m = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        chk("post_reset_no_stale", n, 0);
        chk("post_reset_in_ready", bus.in_ready, 1);
        @(posedge clk); #1;

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
            a  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            b  = 8'($urandom);
            issue(op, a, b, 8'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        rand_ready = 1'b0;
        forced_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_queue_alu_seq
`default_nettype wire
